// File: rtl/serial_pattern_tx_pkg.sv
// -----------------------------------------------------------------------------
// serial_pattern_tx_pkg
//
// Shared definitions for the serial pattern transmitter slice:
//   - default values for the WIDTH / GAP / CNT_W parameters
//   - FSM state encoding constants (IDLE, SHIFT, GAP)
//   - small helper functions used by the top level
//
// No ports (package).
// -----------------------------------------------------------------------------
package serial_pattern_tx_pkg;

    // Default parameter values shared by the top, the interface and the
    // fall edge counter so every instance agrees unless overridden.
    localparam int DEF_WIDTH = 8;
    localparam int DEF_GAP   = 2;
    localparam int DEF_CNT_W = 16;

    // Gap counter is sized for the largest legal GAP (15).
    localparam int GAP_CNT_W = 4;

    // FSM state encoding. Kept as plain constants so older code that
    // compares against raw 2-bit values keeps working.
    typedef logic [1:0] state_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    // True when the FSM is able to take a new word.
    function automatic logic state_accepts(input state_t s);
        return (s == ST_IDLE);
    endfunction

    // True when the FSM is driving a data bit onto the serial line.
    function automatic logic state_drives_data(input state_t s);
        return (s == ST_SHIFT);
    endfunction

endpackage

// File: rtl/serial_pattern_tx_if.sv
// -----------------------------------------------------------------------------
// serial_pattern_tx_if
//
// Bundles the word-input handshake and the serial output of the transmitter.
//
// Signals:
//   DIN        [WIDTH-1:0]  parallel word to transmit        (master -> slave)
//   DIN_VALID               DIN holds a word                 (master -> slave)
//   DIN_READY               transmitter can take a word      (slave -> master)
//   SOUT                    serial data line, idle low       (slave -> master)
//   SOUT_VALID              SOUT carries a data bit          (slave -> master)
//
// Modports:
//   master  - the word producer / line observer
//   slave   - the transmitter
// -----------------------------------------------------------------------------
interface serial_pattern_tx_if
    import serial_pattern_tx_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);

    logic [WIDTH-1:0] DIN;
    logic             DIN_VALID;
    logic             DIN_READY;
    logic             SOUT;
    logic             SOUT_VALID;

    modport master (
        output DIN,
        output DIN_VALID,
        input  DIN_READY,
        input  SOUT,
        input  SOUT_VALID
    );

    modport slave (
        input  DIN,
        input  DIN_VALID,
        output DIN_READY,
        output SOUT,
        output SOUT_VALID
    );

endinterface

// File: rtl/serial_pattern_tx_fall_edge_counter.sv
// -----------------------------------------------------------------------------
// fall_edge_counter
//
// Counts 1->0 transitions on a serial bit stream. The count moves in the
// cycle after the line has dropped, and wraps modulo 2^CNT_W.
// Written to be reusable on the receiving/detector side as well.
//
// Ports:
//   CLK        clock, rising edge
//   RST        synchronous reset, active low
//   serial_in  serial bit being watched
//   count      [CNT_W-1:0] running number of falling transitions
// -----------------------------------------------------------------------------
module fall_edge_counter
    import serial_pattern_tx_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             serial_in,
    output logic [CNT_W-1:0] count
);

    logic             prev_reg;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;

    // A fall is "last cycle high, this cycle low". Because prev_reg is
    // cleared by reset, a drop that reset itself forces on the line is
    // never seen as a fall.
    always_comb begin
        count_next = count_reg;
        if (prev_reg && !serial_in) begin
            count_next = count_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            prev_reg  <= 1'b0;
            count_reg <= '0;
        end else begin
            prev_reg  <= serial_in;
            count_reg <= count_next;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/serial_pattern_tx.sv
// -----------------------------------------------------------------------------
// serial_pattern_tx
//
// Parallel-to-serial transmitter. A word accepted through the bus handshake
// is shifted out MSB first, one bit per cycle, followed by GAP idle-low
// cycles before the next word may be taken. A running count of falling
// transitions on the serial line is kept alongside.
//
// Parameters:
//   WIDTH  bits per word (2..32)
//   GAP    idle-low cycles after each word (0..15)
//   CNT_W  width of FALL_CNT
//
// Ports:
//   CLK       clock, rising edge
//   RST       synchronous reset, active low
//   bus       serial_pattern_tx_if.slave (DIN, DIN_VALID, DIN_READY,
//             SOUT, SOUT_VALID)
//   BUSY      high while a word is being shifted or in its gap
//   FALL_CNT  [CNT_W-1:0] count of 1->0 transitions on SOUT since reset
// -----------------------------------------------------------------------------
module serial_pattern_tx
    import serial_pattern_tx_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int GAP   = DEF_GAP,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             CLK,
    input  logic             RST,
    serial_pattern_tx_if.slave bus,
    output logic             BUSY,
    output logic [CNT_W-1:0] FALL_CNT
);

    localparam int BIT_W = $clog2(WIDTH);

    // Index of the last data bit within a word, and of the last gap cycle.
    localparam logic [BIT_W-1:0]     BIT_LAST = BIT_W'(WIDTH - 1);
    localparam logic [GAP_CNT_W-1:0] GAP_LAST = GAP_CNT_W'((GAP > 0) ? GAP - 1 : 0);

    state_t               state_reg,   state_next;
    logic [WIDTH-1:0]     shift_reg,   shift_next;
    logic [BIT_W-1:0]     bit_cnt_reg, bit_cnt_next;
    logic [GAP_CNT_W-1:0] gap_cnt_reg, gap_cnt_next;

    logic ready;
    logic sout_bit;
    logic sout_valid;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next   = state_reg;
        shift_next   = shift_reg;
        bit_cnt_next = bit_cnt_reg;
        gap_cnt_next = gap_cnt_reg;

        case (state_reg)
            ST_IDLE: begin
                // DIN/DIN_VALID are only looked at here, so changes while
                // a word is in flight cannot disturb the line.
                if (bus.DIN_VALID) begin
                    shift_next   = bus.DIN;
                    bit_cnt_next = '0;
                    state_next   = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                // The MSB of shift_reg is always the bit on the line, so
                // shift every SHIFT cycle. After the last bit the register
                // has shifted itself back to zero.
                shift_next = {shift_reg[WIDTH-2:0], 1'b0};
                if (bit_cnt_reg == BIT_LAST) begin
                    gap_cnt_next = '0;
                    state_next   = (GAP == 0) ? ST_IDLE : ST_GAP;
                end else begin
                    bit_cnt_next = bit_cnt_reg + BIT_W'(1);
                end
            end

            ST_GAP: begin
                if (gap_cnt_reg == GAP_LAST) begin
                    state_next = ST_IDLE;
                end else begin
                    gap_cnt_next = gap_cnt_reg + GAP_CNT_W'(1);
                end
            end

            default: begin
                // Unused encoding: fall back to a clean idle.
                state_next   = ST_IDLE;
                shift_next   = '0;
                bit_cnt_next = '0;
                gap_cnt_next = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_reg   <= ST_IDLE;
            shift_reg   <= '0;
            bit_cnt_reg <= '0;
            gap_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            shift_reg   <= shift_next;
            bit_cnt_reg <= bit_cnt_next;
            gap_cnt_reg <= gap_cnt_next;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: decoded purely from registered state, so nothing on the input
    // side of the handshake reaches an output in the same cycle.
    // -------------------------------------------------------------------------
    assign ready      = state_accepts(state_reg);
    assign sout_valid = state_drives_data(state_reg);
    assign sout_bit   = sout_valid & shift_reg[WIDTH-1];

    assign bus.DIN_READY  = ready;
    assign bus.SOUT       = sout_bit;
    assign bus.SOUT_VALID = sout_valid;
    assign BUSY           = ~ready;

    // -------------------------------------------------------------------------
    // Falling transition counter on the serial line
    // -------------------------------------------------------------------------
    fall_edge_counter #(
        .CNT_W (CNT_W)
    ) u_fall_cnt (
        .CLK       (CLK),
        .RST       (RST),
        .serial_in (sout_bit),
        .count     (FALL_CNT)
    );

endmodule

// File: tb/tb_serial_pattern_tx.sv
// -----------------------------------------------------------------------------
// tb_serial_pattern_tx
//
// Three transmitter instances with different parameter sets:
//   inst 0: WIDTH=8 GAP=2 CNT_W=16   (reset, single word, back-to-back,
//                                     reset mid-word)
//   inst 1: WIDTH=8 GAP=2 CNT_W=4    (counter wrap)
//   inst 2: WIDTH=4 GAP=0 CNT_W=16   (zero gap)
// Each instance has a queue-based reference model and a per-cycle compare;
// the directed scenarios add literal expectations on top.
// -----------------------------------------------------------------------------
module tb_serial_pattern_tx;

    localparam int N_INST = 3;
    localparam int CFG_W [N_INST] = '{8, 8, 4};
    localparam int CFG_G [N_INST] = '{2, 2, 0};
    localparam int CFG_C [N_INST] = '{16, 4, 16};

    logic        clk;
    logic        rst_n     [N_INST];
    logic [31:0] din_drv   [N_INST];
    logic        valid_drv [N_INST];

    logic        o_sout [N_INST];
    logic        o_sv   [N_INST];
    logic        o_rdy  [N_INST];
    logic        o_busy [N_INST];
    logic [15:0] o_cnt  [N_INST];

    logic chk_en;
    int   n_checks;
    int   n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // -------------------------------------------------------------------------
    // DUTs, models and per-cycle compare
    // -------------------------------------------------------------------------
    for (genvar gi = 0; gi < N_INST; gi++) begin : g_inst
        localparam int W = CFG_W[gi];
        localparam int G = CFG_G[gi];
        localparam int C = CFG_C[gi];

        serial_pattern_tx_if #(.WIDTH(W)) bus ();

        logic         busy_w;
        logic [C-1:0] cnt_w;

        assign bus.DIN       = din_drv[gi][W-1:0];
        assign bus.DIN_VALID = valid_drv[gi];

        serial_pattern_tx #(
            .WIDTH (W),
            .GAP   (G),
            .CNT_W (C)
        ) dut (
            .CLK      (clk),
            .RST      (rst_n[gi]),
            .bus      (bus),
            .BUSY     (busy_w),
            .FALL_CNT (cnt_w)
        );

        assign o_sout[gi] = bus.SOUT;
        assign o_sv[gi]   = bus.SOUT_VALID;
        assign o_rdy[gi]  = bus.DIN_READY;
        assign o_busy[gi] = busy_w;
        assign o_cnt[gi]  = 16'(cnt_w);

        // Model: an accepted word becomes a list of line items
        // {data, valid}: W data bits MSB first, then G idle zeros. One item
        // is emitted per cycle; the block is ready when nothing is emitted.
        logic [1:0] m_q [$];
        logic [1:0] m_item;
        logic       m_out, m_val, m_busy, m_last;
        int         m_cnt;

        always @(posedge clk) begin
            if (!rst_n[gi]) begin
                m_q.delete();
                m_out  = 1'b0;
                m_val  = 1'b0;
                m_busy = 1'b0;
                m_last = 1'b0;
                m_cnt  = 0;
            end else begin
                if (m_last && !m_out) m_cnt = (m_cnt + 1) % (1 << C);
                m_last = m_out;
                if (!m_busy && valid_drv[gi]) begin
                    for (int k = W - 1; k >= 0; k--) m_q.push_back({din_drv[gi][k], 1'b1});
                    for (int k = 0; k < G; k++) m_q.push_back(2'b00);
                end
                if (m_q.size() > 0) begin
                    m_item = m_q.pop_front();
                    m_out  = m_item[1];
                    m_val  = m_item[0];
                    m_busy = 1'b1;
                end else begin
                    m_out  = 1'b0;
                    m_val  = 1'b0;
                    m_busy = 1'b0;
                end
            end
        end

        always @(negedge clk) begin
            if (chk_en) begin
                check($sformatf("i%0d cyc SOUT", gi),       32'(bus.SOUT),       32'(m_out));
                check($sformatf("i%0d cyc SOUT_VALID", gi), 32'(bus.SOUT_VALID), 32'(m_val));
                check($sformatf("i%0d cyc DIN_READY", gi),  32'(bus.DIN_READY),  32'(!m_busy));
                check($sformatf("i%0d cyc BUSY", gi),       32'(busy_w),         32'(m_busy));
                check($sformatf("i%0d cyc FALL_CNT", gi),   32'(cnt_w),          32'(m_cnt));
            end
        end
    end

    // Sends one word on instance i and returns the nbits line values seen
    // while it is shifted; returns after the gap, with the block idle.
    task automatic send_word(input int i, input logic [31:0] word, input int nbits,
                             input int gap, output logic [31:0] bits, output int nvalid);
        din_drv[i]   = word;
        valid_drv[i] = 1'b1;
        tick();
        valid_drv[i] = 1'b0;
        bits   = '0;
        nvalid = 0;
        for (int k = 0; k < nbits; k++) begin
            bits = {bits[30:0], o_sout[i]};
            if (o_sv[i]) nvalid++;
            tick();
        end
        for (int k = 0; k < gap; k++) tick();
        $display("inst %0d: word %0h sent, line bits %0h, fall count %0d", i, word, bits, o_cnt[i]);
    endtask

    task automatic do_reset(input int i);
        rst_n[i] = 1'b0;
        tick();
        rst_n[i] = 1'b1;
    endtask

    // -------------------------------------------------------------------------
    // Directed scenarios
    // -------------------------------------------------------------------------
    initial begin
        logic [31:0] bits;
        int          nv;
        logic [7:0]  pat_a;
        logic [20:0] stream_b;
        logic [20:0] exp_b;
        logic [8:0]  stream_e;
        logic [8:0]  exp_e;
        int          t_first, t_second;
        int          exp_wrap [4];

        n_checks = 0;
        n_fail   = 0;
        chk_en   = 1'b0;
        for (int i = 0; i < N_INST; i++) begin
            rst_n[i]     = 1'b0;
            din_drv[i]   = '0;
            valid_drv[i] = 1'b0;
        end

        // Reset held 3 cycles with a word offered on inst 0.
        din_drv[0]   = 32'hFF;
        valid_drv[0] = 1'b1;
        @(posedge clk);
        #1 chk_en = 1'b1;
        @(negedge clk);
        for (int r = 0; r < 3; r++) begin
            if (r > 0) tick();
            check("rst SOUT",       32'(o_sout[0]), 32'd0);
            check("rst SOUT_VALID", 32'(o_sv[0]),   32'd0);
            check("rst DIN_READY",  32'(o_rdy[0]),  32'd1);
            check("rst FALL_CNT",   32'(o_cnt[0]),  32'd0);
        end
        for (int i = 0; i < N_INST; i++) rst_n[i] = 1'b1;
        valid_drv[0] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("post-rst SOUT_VALID", 32'(o_sv[0]), 32'd0);
        end
        $display("inst 0: reset with DIN_VALID high, no transfer");

        // Single word A5.
        pat_a        = 8'hA5;
        din_drv[0]   = 32'hA5;
        valid_drv[0] = 1'b1;
        tick();
        valid_drv[0] = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check($sformatf("A5 bit%0d", 7 - k), 32'(o_sout[0]), 32'(pat_a[7 - k]));
            check("A5 SOUT_VALID", 32'(o_sv[0]), 32'd1);
            tick();
        end
        for (int k = 0; k < 2; k++) begin
            check("A5 gap SOUT",       32'(o_sout[0]), 32'd0);
            check("A5 gap SOUT_VALID", 32'(o_sv[0]),   32'd0);
            check("A5 gap DIN_READY",  32'(o_rdy[0]),  32'd0);
            tick();
        end
        check("A5 ready after gap", 32'(o_rdy[0]), 32'd1);
        check("A5 FALL_CNT",        32'(o_cnt[0]), 32'd4);
        $display("inst 0: word a5 sent, fall count %0d", o_cnt[0]);

        // Back-to-back FF then 00 with DIN_VALID held.
        do_reset(0);
        din_drv[0]   = 32'hFF;
        valid_drv[0] = 1'b1;
        t_first  = -1;
        t_second = -1;
        stream_b = '0;
        for (int e = 0; e < 21; e++) begin
            if (o_rdy[0] && valid_drv[0]) begin
                if (t_first < 0) t_first = e;
                else if (t_second < 0) t_second = e;
            end
            tick();
            if (e == 0) din_drv[0] = 32'h00;
            stream_b = {stream_b[19:0], o_sout[0]};
        end
        valid_drv[0] = 1'b0;
        exp_b = {8'hFF, 13'h0};
        check("b2b stream",  32'(stream_b), 32'(exp_b));
        check("b2b spacing", 32'(t_second - t_first), 32'd11);
        tick();
        tick();
        check("b2b FALL_CNT", 32'(o_cnt[0]), 32'd1);
        $display("inst 0: words ff,00 back-to-back, spacing %0d, fall count %0d",
                 t_second - t_first, o_cnt[0]);

        // Reset in the middle of AA, then a fresh 80.
        do_reset(0);
        din_drv[0]   = 32'hAA;
        valid_drv[0] = 1'b1;
        tick();
        valid_drv[0] = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        check("AA bit3 on line",   32'(o_sout[0]), 32'd1);
        check("AA FALL_CNT so far", 32'(o_cnt[0]), 32'd2);
        rst_n[0] = 1'b0;
        tick();
        check("abort SOUT",       32'(o_sout[0]), 32'd0);
        check("abort SOUT_VALID", 32'(o_sv[0]),   32'd0);
        check("abort BUSY",       32'(o_busy[0]), 32'd0);
        check("abort FALL_CNT",   32'(o_cnt[0]),  32'd0);
        rst_n[0] = 1'b1;
        tick();
        check("abort DIN_READY",  32'(o_rdy[0]),  32'd1);
        tick();
        check("abort no fall counted", 32'(o_cnt[0]), 32'd0);
        check("abort no bits",         32'(o_sv[0]),  32'd0);
        $display("inst 0: word aa aborted by reset");
        send_word(0, 32'h80, 8, 2, bits, nv);
        check("80 bits",     bits,           32'h80);
        check("80 nvalid",   32'(nv),        32'd8);
        check("80 FALL_CNT", 32'(o_cnt[0]),  32'd1);

        // Counter wrap on a 4-bit FALL_CNT.
        exp_wrap = '{4, 8, 12, 0};
        do_reset(1);
        for (int w = 0; w < 4; w++) begin
            send_word(1, 32'hAA, 8, 2, bits, nv);
            check("wrap bits", bits, 32'hAA);
            check($sformatf("wrap FALL_CNT word%0d", w), 32'(o_cnt[1]), 32'(exp_wrap[w]));
        end

        // Zero gap, 4-bit words 9 and 6 back-to-back.
        do_reset(2);
        din_drv[2]   = 32'h9;
        valid_drv[2] = 1'b1;
        t_first  = -1;
        t_second = -1;
        stream_e = '0;
        for (int e = 0; e < 9; e++) begin
            if (o_rdy[2] && valid_drv[2]) begin
                if (t_first < 0) t_first = e;
                else if (t_second < 0) t_second = e;
            end
            tick();
            if (e == 0) din_drv[2] = 32'h6;
            stream_e = {stream_e[7:0], o_sout[2]};
        end
        valid_drv[2] = 1'b0;
        exp_e = 9'b100100110;
        check("gap0 stream",  32'(stream_e), 32'(exp_e));
        check("gap0 spacing", 32'(t_second - t_first), 32'd5);
        tick();
        tick();
        check("gap0 FALL_CNT", 32'(o_cnt[2]), 32'd3);
        check("gap0 idle",     32'(o_rdy[2]), 32'd1);
        $display("inst 2: words 9,6 with no gap, spacing %0d, fall count %0d",
                 t_second - t_first, o_cnt[2]);

        tick();
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_pattern_tx.md
SERIAL_PATTERN_TX -- requirements
Module: serial_pattern_tx

Interface
REQ-001 Parameter WIDTH, default 8: bits per word, shifted MSB first; legal range 2..32.
REQ-002 Parameter GAP, default 2: idle-low cycles inserted after each word; legal range 0..15.
REQ-003 Parameter CNT_W, default 16: width of FALL_CNT.
REQ-004 CLK  input  1  clock; all state changes on the rising edge.
REQ-005 RST  input  1  reset, synchronous, active-low.
REQ-006 DIN  input  WIDTH  parallel word to transmit.
REQ-007 DIN_VALID  input  1  DIN holds a word to send.
REQ-008 DIN_READY  output  1  block can accept a word this cycle.
REQ-009 SOUT  output  1  serial data line, idle level 0.
REQ-010 SOUT_VALID  output  1  SOUT carries a data bit this cycle.
REQ-011 BUSY  output  1  block is in SHIFT or GAP.
REQ-012 FALL_CNT  output  CNT_W  running count of 1->0 transitions on SOUT since reset.

Function
REQ-013 The block SHALL implement three states: IDLE, SHIFT and GAP.
REQ-014 DIN_READY SHALL be 1 exactly when the state is IDLE; BUSY SHALL be its complement.
REQ-015 A transfer SHALL occur on a rising edge when DIN_VALID=1 and DIN_READY=1; DIN is captured into a WIDTH-bit shift register and the state moves to SHIFT.
REQ-016 In SHIFT, SOUT SHALL present captured bits WIDTH-1 down to 0, one per cycle, with SOUT_VALID=1; the first bit is visible in the cycle after the capture edge.
REQ-017 After bit 0, the state SHALL move to GAP for GAP cycles (SOUT=0, SOUT_VALID=0), then to IDLE; with GAP=0 it moves directly to IDLE.
REQ-018 In IDLE, SOUT and SOUT_VALID SHALL be 0.
REQ-019 The accept-to-accept spacing for back-to-back words SHALL be WIDTH+GAP+1 cycles.
REQ-020 DIN and DIN_VALID SHALL be ignored outside IDLE; changing them mid-word has no effect on SOUT.
REQ-021 All outputs SHALL be registered or decoded only from registered state, with no combinational path from DIN or DIN_VALID to any output.
REQ-022 FALL_CNT SHALL increment by 1 in the cycle after SOUT goes from 1 to 0, including a final data 1 followed by the gap or idle 0.
REQ-023 FALL_CNT SHALL wrap modulo 2^CNT_W without saturating or flagging.

Reset
REQ-024 While RST=0 at a rising edge, the block SHALL set: state IDLE, SOUT=0, SOUT_VALID=0, shift register 0, bit and gap counters 0, FALL_CNT=0.
REQ-025 While RST=0, DIN_VALID SHALL NOT cause a transfer.
REQ-026 Reset asserted mid-SHIFT or mid-GAP SHALL abort the word with no further bits emitted; DIN_READY=1 in the first cycle after RST returns to 1.
REQ-027 A 1->0 on SOUT caused by reset SHALL NOT be counted.

Structure
REQ-028 The state encoding constants (IDLE, SHIFT, GAP) and the default WIDTH, GAP and CNT_W values SHALL live in the shared package.
REQ-029 The FALL_CNT logic SHALL be one sub-module, fall_edge_counter (inputs CLK, RST, serial bit; output count), reusable on the detector side.
REQ-030 The top level SHALL hold the FSM, the shift register, the bit counter and the gap counter.

Verification
REQ-031 Reset: RST=0 for 3 cycles with DIN_VALID=1, DIN=8'hFF -> SOUT=0, SOUT_VALID=0, DIN_READY=1, FALL_CNT=0, no bits emitted after release.
REQ-032 Single word: DIN=8'hA5 accepted at edge 0 -> SOUT 1,0,1,0,0,1,0,1 after edges 0..7 with SOUT_VALID=1; 0,0 gap after edges 8..9; DIN_READY=1 after edge 10; FALL_CNT=4.
REQ-033 Back-to-back: DIN_VALID held, DIN=8'hFF then 8'h00 -> second accept exactly 11 cycles after first; stream 8 ones then 13 zeros; FALL_CNT=1.
REQ-034 Reset mid-word: 8'hAA with RST=0 during bit 3 -> next cycle SOUT=0, SOUT_VALID=0, BUSY=0, FALL_CNT=0; a fresh 8'h80 then sends correctly with FALL_CNT=1.
REQ-035 Wrap: CNT_W=4, four words 8'hAA -> FALL_CNT reads 4, 8, 12, then 0 after the fourth word.
REQ-036 GAP=0, WIDTH=4: words 4'h9 and 4'h6 back-to-back -> SOUT 1,0,0,1,0(idle),0,1,1,0 and accept spacing 5 cycles.
